// File: rtl/instr_realign_gen.sv
// Instruction re-aligner between I$ fetch and the instruction queue: splits a fetch block
// into packed RV32/RVC slots and carries the lower half of a block-straddling instruction.
module instr_realign_gen #(
   parameter int FETCH_WIDTH = 64,
   parameter int ADDR_W      = 64
) (
   input  logic                                  clk_i,
   input  logic                                  rst_ni,
   input  logic                                  flush_i,
   input  logic                                  valid_i,
   output logic                                  ready_o,
   input  logic [ADDR_W-1:0]                     address_i,
   input  logic [FETCH_WIDTH-1:0]                data_i,
   input  logic                                  ready_i,
   output logic [FETCH_WIDTH/16-1:0]             valid_o,
   output logic [FETCH_WIDTH/16-1:0][ADDR_W-1:0] addr_o,
   output logic [FETCH_WIDTH/16-1:0][31:0]       instr_o,
   output logic                                  serving_unaligned_o
);

   localparam int NR_SLOTS = FETCH_WIDTH / 16;
   localparam int OFF_W    = $clog2(FETCH_WIDTH / 8);
   localparam int SLOT_W   = $clog2(NR_SLOTS);

   logic                   carry_q, carry_d;
   logic [15:0]            carry_instr_q, carry_instr_d;
   logic [ADDR_W-1:0]      carry_addr_q, carry_addr_d;
   logic                   fire, use_carry, out_en;
   logic [ADDR_W-1:0]      block_base;
   logic [SLOT_W-1:0]      start_hw;
   logic [FETCH_WIDTH+15:0] data_ext;

   assign ready_o             = ready_i;
   assign fire                = valid_i & ready_i & ~flush_i;
   assign out_en              = valid_i & ~flush_i;
   assign serving_unaligned_o = carry_q;
   assign block_base          = {address_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
   assign use_carry           = carry_q & (address_i == carry_addr_q + ADDR_W'(2));
   // a carried lower half always pairs with halfword 0 of the next block
   assign start_hw            = use_carry ? SLOT_W'(1) : address_i[OFF_W-1:1];
   // zero pad so a 32-bit select at the top halfword stays in range
   assign data_ext            = {16'h0000, data_i};

   always_comb begin
      logic [SLOT_W-1:0] k;
      logic              skip;
      logic [15:0]       hw;
      valid_o       = '0;
      addr_o        = '0;
      instr_o       = '0;
      carry_d       = 1'b0;
      carry_instr_d = carry_instr_q;
      carry_addr_d  = carry_addr_q;
      k             = '0;
      skip          = 1'b0;
      hw            = '0;
      if (use_carry) begin
         valid_o[0] = 1'b1;
         addr_o[0]  = carry_addr_q;
         instr_o[0] = {data_i[15:0], carry_instr_q};
         k          = SLOT_W'(1);
      end
      for (int i = 0; i < NR_SLOTS; i++) begin
         hw = data_i[16*i +: 16];
         if (skip) begin
            skip = 1'b0;
         end else if (i >= int'(start_hw)) begin
            if (hw[1:0] != 2'b11) begin
               valid_o[k] = 1'b1;
               addr_o[k]  = block_base + ADDR_W'(2 * i);
               instr_o[k] = {16'h0000, hw};
               k          = k + SLOT_W'(1);
            end else if (i < NR_SLOTS - 1) begin
               valid_o[k] = 1'b1;
               addr_o[k]  = block_base + ADDR_W'(2 * i);
               instr_o[k] = data_ext[16*i +: 32];
               k          = k + SLOT_W'(1);
               skip       = 1'b1;
            end else begin
               carry_d       = 1'b1;
               carry_instr_d = hw;
               carry_addr_d  = block_base + ADDR_W'(2 * (NR_SLOTS - 1));
            end
         end
      end
      if (!out_en) begin
         valid_o = '0;
         addr_o  = '0;
         instr_o = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         carry_q       <= 1'b0;
         carry_instr_q <= '0;
         carry_addr_q  <= '0;
      end else if (flush_i) begin
         carry_q <= 1'b0;
      end else if (fire) begin
         carry_q       <= carry_d;
         carry_instr_q <= carry_instr_d;
         carry_addr_q  <= carry_addr_d;
      end
   end

endmodule
